// File: rtl/stage_decode.sv
// stage_decode: decode stage sitting behind fetch.
// Holds the 32x32 integer register file (written by writeback), RV32I
// immediate generation and control decode, and the decode/execute pipeline
// register with flush (bubble) and stall (hold).
// Optional build macro REGFILE_BYPASS_EN: when defined, a writeback to the
// register being read in the same cycle is forwarded to the read port.
module stage_decode #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_decode,
  input  logic            stall_decode,
  input  logic [XLEN-1:0] fetch_instr,
  input  logic [XLEN-1:0] fetch_instr_addr,
  input  logic [XLEN-1:0] fetch_instr_addr_plus,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] decode_rs1_data,
  output logic [XLEN-1:0] decode_rs2_data,
  output logic [XLEN-1:0] decode_imm,
  output logic [4:0]      decode_rs1,
  output logic [4:0]      decode_rs2,
  output logic [4:0]      decode_rd,
  output logic [2:0]      decode_funct3,
  output logic [3:0]      decode_alu_op,
  output logic [1:0]      decode_alu_src_a,
  output logic            decode_alu_src_b,
  output logic            decode_reg_write,
  output logic            decode_mem_read,
  output logic            decode_mem_write,
  output logic            decode_branch,
  output logic            decode_jal,
  output logic            decode_jalr,
  output logic [1:0]      decode_wb_sel,
  output logic            decode_illegal,
  output logic [XLEN-1:0] decode_instr_addr,
  output logic [XLEN-1:0] decode_instr_addr_plus
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [1:0] SRC_A_RS1  = 2'd0;
  localparam logic [1:0] SRC_A_PC   = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // Everything carried across the decode/execute boundary.
  typedef struct packed {
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [3:0]      alu_op;
    logic [1:0]      alu_src_a;
    logic            alu_src_b;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jal;
    logic            jalr;
    logic [1:0]      wb_sel;
    logic            illegal;
    logic [XLEN-1:0] instr_addr;
    logic [XLEN-1:0] instr_addr_plus;
  } dx_t;

  logic [XLEN-1:0] r_regs [REG_COUNT];
  dx_t             r_dx;
  dx_t             w_dx;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd_field;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;
  logic            w_wb_hit_rs1;
  logic            w_wb_hit_rs2;

  assign w_opcode   = fetch_instr[6:0];
  assign w_rd_field = fetch_instr[11:7];
  assign w_funct3   = fetch_instr[14:12];
  assign w_rs1      = fetch_instr[19:15];
  assign w_rs2      = fetch_instr[24:20];

  assign w_imm_i = {{20{fetch_instr[31]}}, fetch_instr[31:20]};
  assign w_imm_s = {{20{fetch_instr[31]}}, fetch_instr[31:25], fetch_instr[11:7]};
  assign w_imm_b = {{19{fetch_instr[31]}}, fetch_instr[31], fetch_instr[7],
                    fetch_instr[30:25], fetch_instr[11:8], 1'b0};
  assign w_imm_u = {fetch_instr[31:12], 12'b0};
  assign w_imm_j = {{11{fetch_instr[31]}}, fetch_instr[31], fetch_instr[19:12],
                    fetch_instr[20], fetch_instr[30:21], 1'b0};

  // A writeback to x0 is discarded, so it never counts as a hit.
  assign w_wb_hit_rs1 = wb_reg_write && (wb_rd != 5'd0) && (wb_rd == w_rs1);
  assign w_wb_hit_rs2 = wb_reg_write && (wb_rd != 5'd0) && (wb_rd == w_rs2);

  // Register file: reset clears every entry; x0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wb_reg_write && (wb_rd != 5'd0)) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  // Combinational read ports; x0 reads as zero regardless of array contents.
  always_comb begin
    w_rs1_data = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
    w_rs2_data = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];
`ifdef REGFILE_BYPASS_EN
    if (w_wb_hit_rs1) w_rs1_data = wb_data;
    if (w_wb_hit_rs2) w_rs2_data = wb_data;
`endif
  end

`ifndef REGFILE_BYPASS_EN
  // Without forwarding the hit terms only matter to the hazard unit outside.
  logic w_unused_hit;
  assign w_unused_hit = w_wb_hit_rs1 ^ w_wb_hit_rs2;
`endif

  // Control decode; unknown opcodes and the all-zero fetch bubble leave
  // every control at zero, only the former raises illegal.
  always_comb begin
    w_dx                 = '0;
    w_dx.rs1_data        = w_rs1_data;
    w_dx.rs2_data        = w_rs2_data;
    w_dx.rs1             = w_rs1;
    w_dx.rs2             = w_rs2;
    w_dx.funct3          = w_funct3;
    w_dx.alu_src_a       = SRC_A_RS1;
    w_dx.wb_sel          = WB_ALU;
    w_dx.instr_addr      = fetch_instr_addr;
    w_dx.instr_addr_plus = fetch_instr_addr_plus;
    case (w_opcode)
      OPC_OP: begin
        w_dx.reg_write = 1'b1;
        w_dx.alu_op    = {fetch_instr[30], w_funct3};
      end
      OPC_OP_IMM: begin
        w_dx.alu_src_b = 1'b1;
        w_dx.reg_write = 1'b1;
        w_dx.imm       = w_imm_i;
        // Only SRLI/SRAI use bit 30; for the others it is immediate data.
        w_dx.alu_op    = {(w_funct3 == 3'b101) && fetch_instr[30], w_funct3};
      end
      OPC_LOAD: begin
        w_dx.alu_src_b = 1'b1;
        w_dx.reg_write = 1'b1;
        w_dx.mem_read  = 1'b1;
        w_dx.wb_sel    = WB_MEM;
        w_dx.imm       = w_imm_i;
      end
      OPC_STORE: begin
        w_dx.alu_src_b = 1'b1;
        w_dx.mem_write = 1'b1;
        w_dx.imm       = w_imm_s;
      end
      OPC_BRANCH: begin
        w_dx.branch = 1'b1;
        w_dx.alu_op = 4'b1000;
        w_dx.imm    = w_imm_b;
      end
      OPC_LUI: begin
        w_dx.alu_src_a = SRC_A_ZERO;
        w_dx.alu_src_b = 1'b1;
        w_dx.reg_write = 1'b1;
        w_dx.imm       = w_imm_u;
      end
      OPC_AUIPC: begin
        w_dx.alu_src_a = SRC_A_PC;
        w_dx.alu_src_b = 1'b1;
        w_dx.reg_write = 1'b1;
        w_dx.imm       = w_imm_u;
      end
      OPC_JAL: begin
        w_dx.jal       = 1'b1;
        w_dx.reg_write = 1'b1;
        w_dx.wb_sel    = WB_PC4;
        w_dx.imm       = w_imm_j;
      end
      OPC_JALR: begin
        w_dx.jalr      = 1'b1;
        w_dx.alu_src_b = 1'b1;
        w_dx.reg_write = 1'b1;
        w_dx.wb_sel    = WB_PC4;
        w_dx.imm       = w_imm_i;
      end
      default: begin
        w_dx.illegal = (fetch_instr != '0);
      end
    endcase
    // A zero rd keeps the hazard/forwarding logic from matching non-writers.
    w_dx.rd = w_dx.reg_write ? w_rd_field : 5'd0;
  end

  // Decode/execute register: reset, then flush, then stall, then load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dx <= '0;
    end else if (flush_decode) begin
      r_dx <= '0;
    end else if (!stall_decode) begin
      r_dx <= w_dx;
    end
  end

  assign decode_rs1_data        = r_dx.rs1_data;
  assign decode_rs2_data        = r_dx.rs2_data;
  assign decode_imm             = r_dx.imm;
  assign decode_rs1             = r_dx.rs1;
  assign decode_rs2             = r_dx.rs2;
  assign decode_rd              = r_dx.rd;
  assign decode_funct3          = r_dx.funct3;
  assign decode_alu_op          = r_dx.alu_op;
  assign decode_alu_src_a       = r_dx.alu_src_a;
  assign decode_alu_src_b       = r_dx.alu_src_b;
  assign decode_reg_write       = r_dx.reg_write;
  assign decode_mem_read        = r_dx.mem_read;
  assign decode_mem_write       = r_dx.mem_write;
  assign decode_branch          = r_dx.branch;
  assign decode_jal             = r_dx.jal;
  assign decode_jalr            = r_dx.jalr;
  assign decode_wb_sel          = r_dx.wb_sel;
  assign decode_illegal         = r_dx.illegal;
  assign decode_instr_addr      = r_dx.instr_addr;
  assign decode_instr_addr_plus = r_dx.instr_addr_plus;

endmodule
